// File: rtl/switch_led_io.sv
// Memory-mapped switch/LED peripheral: synchronised and debounced switches, sticky edge flags, LED register, level irq.
// Optional LED brightness PWM is built only when SWITCH_LED_PWM_EN is defined.
module switch_led_io #(
   parameter int SW_WIDTH        = 19,
   parameter int LED_WIDTH       = 24,
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [SW_WIDTH-1:0]  sw_in,
   input  logic                 io_rd,
   input  logic                 io_wr,
   input  logic [2:0]           io_addr,
   input  logic [31:0]          io_wdata,
   output logic [31:0]          io_rdata,
   output logic                 io_rvalid,
   output logic [LED_WIDTH-1:0] led_out,
   output logic                 irq
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [2:0] ADDR_SW_STATUS = 3'd0;
   localparam logic [2:0] ADDR_LED_DATA  = 3'd1;
   localparam logic [2:0] ADDR_SW_EDGE   = 3'd2;
   localparam logic [2:0] ADDR_CTRL      = 3'd3;
   localparam logic [2:0] ADDR_PWM_DUTY  = 3'd4;

   logic [SW_WIDTH-1:0]  sw_meta;
   logic [SW_WIDTH-1:0]  sw_sync;
   logic [SW_WIDTH-1:0]  sw_deb;
   logic [SW_WIDTH-1:0]  deb_next;
   logic [SW_WIDTH-1:0]  edge_set;
   logic [SW_WIDTH-1:0]  sw_edge;
   logic [SW_WIDTH-1:0]  w1c_mask;
   logic [CW-1:0]        db_cnt   [SW_WIDTH];
   logic [CW-1:0]        cnt_next [SW_WIDTH];
   logic [LED_WIDTH-1:0] led_data;
   logic                 led_en;
   logic                 irq_en;
   logic                 pwm_on;
   logic [31:0]          rd_mux;
   logic                 wr_led;
   logic                 wr_ctrl;
   logic                 unused_wdata;

   assign wr_led       = io_wr && (io_addr == ADDR_LED_DATA);
   assign wr_ctrl      = io_wr && (io_addr == ADDR_CTRL);
   assign w1c_mask     = (io_wr && (io_addr == ADDR_SW_EDGE)) ? io_wdata[SW_WIDTH-1:0] : '0;
   assign edge_set     = deb_next & ~sw_deb;
   assign unused_wdata = ^io_wdata;

   // Two-flop synchroniser for the raw, asynchronous board switches
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= sw_in;
         sw_sync <= sw_meta;
      end
   end

   // A bit is accepted only after DEBOUNCE_CYCLES consecutive cycles of disagreement; any agreement restarts the count
   always_comb begin
      deb_next = sw_deb;
      for (int i = 0; i < SW_WIDTH; i++) begin
         cnt_next[i] = '0;
         if (sw_sync[i] != sw_deb[i]) begin
            if (db_cnt[i] == CNT_MAX) begin
               deb_next[i] = sw_sync[i];
            end else begin
               cnt_next[i] = db_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_deb <= '0;
         for (int i = 0; i < SW_WIDTH; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sw_deb <= deb_next;
         for (int i = 0; i < SW_WIDTH; i++) begin
            db_cnt[i] <= cnt_next[i];
         end
      end
   end

   // Sticky rising-edge flags: a new edge in the same cycle as a W1C keeps the flag set
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_edge <= '0;
      end else begin
         sw_edge <= (sw_edge & ~w1c_mask) | edge_set;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led_data <= '0;
         led_en   <= 1'b0;
         irq_en   <= 1'b0;
         irq      <= 1'b0;
      end else begin
         if (wr_led) begin
            led_data <= io_wdata[LED_WIDTH-1:0];
         end
         if (wr_ctrl) begin
            led_en <= io_wdata[0];
            irq_en <= io_wdata[1];
         end
         irq <= irq_en & (|sw_edge);
      end
   end

`ifdef SWITCH_LED_PWM_EN
   logic [7:0] pwm_cnt;
   logic [7:0] pwm_duty;

   // Free-running brightness counter; duty 0 keeps LEDs dark, 255 lights them 255 of 256 cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pwm_cnt  <= '0;
         pwm_duty <= 8'hFF;
      end else begin
         pwm_cnt <= pwm_cnt + 8'd1;
         if (io_wr && (io_addr == ADDR_PWM_DUTY)) begin
            pwm_duty <= io_wdata[7:0];
         end
      end
   end

   assign pwm_on = (pwm_cnt < pwm_duty);
`else
   assign pwm_on = 1'b1;
`endif

   assign led_out = (led_en && pwm_on) ? led_data : '0;

   always_comb begin
      rd_mux = '0;
      case (io_addr)
         ADDR_SW_STATUS: rd_mux[SW_WIDTH-1:0]  = sw_deb;
         ADDR_LED_DATA:  rd_mux[LED_WIDTH-1:0] = led_data;
         ADDR_SW_EDGE:   rd_mux[SW_WIDTH-1:0]  = sw_edge;
         ADDR_CTRL:      rd_mux[1:0]           = {irq_en, led_en};
`ifdef SWITCH_LED_PWM_EN
         ADDR_PWM_DUTY:  rd_mux[7:0]           = pwm_duty;
`endif
         default:        rd_mux                = '0;
      endcase
   end

   // Read data is captured from pre-write register values and held until the next read
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         io_rdata  <= '0;
         io_rvalid <= 1'b0;
      end else begin
         io_rvalid <= io_rd;
         if (io_rd) begin
            io_rdata <= rd_mux;
         end
      end
   end

endmodule

// File: tb/tb_switch_led_io.sv
// Directed self-checking bench for switch_led_io with a short debounce window.
// Covers the PWM path as well when built with SWITCH_LED_PWM_EN.
module tb_switch_led_io;

   localparam int SW_WIDTH  = 19;
   localparam int LED_WIDTH = 24;
   localparam int DEB       = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [SW_WIDTH-1:0]  sw_in;
   logic                 io_rd;
   logic                 io_wr;
   logic [2:0]           io_addr;
   logic [31:0]          io_wdata;
   logic [31:0]          io_rdata;
   logic                 io_rvalid;
   logic [LED_WIDTH-1:0] led_out;
   logic                 irq;

   int errors = 0;
   int checks = 0;

   switch_led_io #(
      .SW_WIDTH(SW_WIDTH),
      .LED_WIDTH(LED_WIDTH),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sw_in(sw_in),
      .io_rd(io_rd),
      .io_wr(io_wr),
      .io_addr(io_addr),
      .io_wdata(io_wdata),
      .io_rdata(io_rdata),
      .io_rvalid(io_rvalid),
      .led_out(led_out),
      .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [SW_WIDTH-1:0] sw, input int cycles);
      sw_in = sw;
      tick(cycles);
   endtask

   task automatic busWrite(input logic [2:0] addr, input logic [31:0] data);
      io_wr    = 1'b1;
      io_addr  = addr;
      io_wdata = data;
      tick(1);
      io_wr    = 1'b0;
   endtask

   task automatic readCheck(input string tag, input logic [2:0] addr, input logic [31:0] exp);
      io_rd   = 1'b1;
      io_addr = addr;
      tick(1);
      io_rd   = 1'b0;
      checkOutput({tag, "_rvalid"}, {31'b0, io_rvalid}, 32'd1);
      checkOutput(tag, io_rdata, exp);
   endtask

   task automatic countLed(input string tag, input int exp);
      int ones;
      ones = 0;
      for (int i = 0; i < 256; i++) begin
         ones += int'(led_out[0]);
         tick(1);
      end
      checkOutput(tag, 32'(ones), 32'(exp));
   endtask

   initial begin
      logic [31:0] led_seen;

      rst      = 1'b0;
      sw_in    = 19'h7FFFF;
      io_rd    = 1'b0;
      io_wr    = 1'b0;
      io_addr  = '0;
      io_wdata = '0;
      tick(3);
      checkOutput("rst_rdata", io_rdata, 32'h0);
      checkOutput("rst_rvalid", {31'b0, io_rvalid}, 32'h0);
      checkOutput("rst_led", {8'b0, led_out}, 32'h0);
      checkOutput("rst_irq", {31'b0, irq}, 32'h0);

      // Debounced status appears exactly 2+DEB edges after release
      rst = 1'b1;
      tick(5);
      readCheck("status_early", 3'd0, 32'h0);
      readCheck("status_rst", 3'd0, 32'h7FFFF);
      readCheck("edge_rst", 3'd2, 32'h7FFFF);
      busWrite(3'd2, 32'h7FFFF);
      readCheck("edge_clr", 3'd2, 32'h0);

      // A 3-cycle pulse is rejected, a 6-cycle hold is accepted
      applyStimulus(19'h7FFFE, 8);
      readCheck("status_low0", 3'd0, 32'h7FFFE);
      applyStimulus(19'h7FFFF, 3);
      applyStimulus(19'h7FFFE, 8);
      readCheck("glitch_status", 3'd0, 32'h7FFFE);
      readCheck("glitch_edge", 3'd2, 32'h0);
      applyStimulus(19'h7FFFF, 6);
      readCheck("hold_status", 3'd0, 32'h7FFFF);
      readCheck("hold_edge", 3'd2, 32'h1);
      busWrite(3'd2, 32'h1);

      busWrite(3'd1, 32'hFFA5A5A5);
      checkOutput("led_disabled", {8'b0, led_out}, 32'h0);
      busWrite(3'd3, 32'h1);
`ifdef SWITCH_LED_PWM_EN
      led_seen = {8'b0, led_out};
      tick(1);
      led_seen = led_seen | {8'b0, led_out};
`else
      led_seen = {8'b0, led_out};
`endif
      checkOutput("led_enabled", led_seen, 32'h00A5A5A5);
      readCheck("led_data", 3'd1, 32'h00A5A5A5);
      busWrite(3'd3, 32'hFFFFFFFF);
      readCheck("ctrl_mask", 3'd3, 32'h3);
      busWrite(3'd3, 32'h1);
      busWrite(3'd0, 32'h0);
      readCheck("status_ro", 3'd0, 32'h7FFFF);

      busWrite(3'd3, 32'h3);
      applyStimulus(19'h7FFFB, 8);
      busWrite(3'd2, 32'h7FFFF);
      tick(1);
      checkOutput("irq_idle", {31'b0, irq}, 32'h0);
      applyStimulus(19'h7FFFF, 6);
      checkOutput("irq_lag", {31'b0, irq}, 32'h0);
      tick(1);
      checkOutput("irq_set", {31'b0, irq}, 32'h1);
      readCheck("edge_bit2", 3'd2, 32'h4);
      busWrite(3'd2, 32'h4);
      checkOutput("irq_w1c_lag", {31'b0, irq}, 32'h1);
      tick(1);
      checkOutput("irq_w1c", {31'b0, irq}, 32'h0);

      // W1C lands on the same edge the debounced bit rises
      applyStimulus(19'h7FFFB, 8);
      applyStimulus(19'h7FFFF, 5);
      busWrite(3'd2, 32'h4);
      tick(1);
      checkOutput("irq_race", {31'b0, irq}, 32'h1);
      readCheck("edge_race", 3'd2, 32'h4);
      busWrite(3'd2, 32'h4);
      busWrite(3'd3, 32'h1);
      tick(1);

      checkOutput("rvalid_idle", {31'b0, io_rvalid}, 32'h0);
      io_rd    = 1'b1;
      io_wr    = 1'b1;
      io_addr  = 3'd1;
      io_wdata = 32'h1;
      tick(1);
      io_rd    = 1'b0;
      io_wr    = 1'b0;
      checkOutput("rdwr_rvalid", {31'b0, io_rvalid}, 32'h1);
      checkOutput("rdwr_old", io_rdata, 32'h00A5A5A5);
      tick(1);
      checkOutput("rvalid_drop", {31'b0, io_rvalid}, 32'h0);
      checkOutput("rdata_hold", io_rdata, 32'h00A5A5A5);
      readCheck("rdwr_new", 3'd1, 32'h1);
      for (int a = 5; a < 8; a++) begin
         readCheck("unmapped", 3'(a), 32'h0);
      end

`ifdef SWITCH_LED_PWM_EN
      readCheck("duty_rst", 3'd4, 32'hFF);
      busWrite(3'd4, 32'd64);
      readCheck("duty_rd", 3'd4, 32'd64);
      countLed("pwm64", 64);
      busWrite(3'd4, 32'd0);
      countLed("pwm0", 0);
      busWrite(3'd4, 32'd255);
`else
      busWrite(3'd4, 32'd64);
      readCheck("duty_absent", 3'd4, 32'h0);
      countLed("led_full", 256);
`endif
      busWrite(3'd3, 32'h0);
      countLed("led_off", 0);

      busWrite(3'd3, 32'h1);
      io_rd   = 1'b1;
      io_addr = 3'd1;
      tick(1);
      io_rd = 1'b0;
      checkOutput("mid_rvalid", {31'b0, io_rvalid}, 32'h1);
      rst = 1'b0;
      #1;
      checkOutput("arst_rvalid", {31'b0, io_rvalid}, 32'h0);
      checkOutput("arst_rdata", io_rdata, 32'h0);
      checkOutput("arst_led", {8'b0, led_out}, 32'h0);
      checkOutput("arst_irq", {31'b0, irq}, 32'h0);
      tick(1);
      rst = 1'b1;
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/switch_led_io.md
Name: switch_led_io

Overview:
- Parametrised memory-mapped switch/LED peripheral for the single-cycle CPU; replaces the fixed 19-switch / 24-LED direct wiring.
- Synchronises and debounces N switch inputs and latches sticky rising-edge flags.
- Drives M LEDs from a CPU-writable register and raises a level interrupt on switch edges.
- Sits between the CPU's IO load/store path and the board pins.

Parameters:
- SW_WIDTH, 19, number of switch inputs (1..32)
- LED_WIDTH, 24, number of LED outputs (1..32)
- DEBOUNCE_CYCLES, 20000, stable cycles required before a switch change is accepted (>=2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- sw_in  in  SW_WIDTH  raw board switches, asynchronous to clk
- io_rd  in  1  read strobe, one cycle
- io_wr  in  1  write strobe, one cycle
- io_addr  in  3  word offset: 0 SW_STATUS, 1 LED_DATA, 2 SW_EDGE, 3 CTRL, 4 PWM_DUTY
- io_wdata  in  32  write data
- io_rdata  out  32  read data, registered
- io_rvalid  out  1  high one cycle after an accepted io_rd
- led_out  out  LED_WIDTH  LED pins
- irq  out  1  level interrupt

Behaviour:
- Reset (rst=0, asynchronous) clears all state: io_rdata=0, io_rvalid=0, led_out=0, irq=0, LED_DATA=0, SW_EDGE=0, CTRL=0, debounced switches=0, counters=0, PWM_DUTY=8'hFF.
- Sync: each sw_in bit passes through a 2-flop synchroniser.
- Debounce: one counter per bit.
  - If the synced bit equals the debounced bit, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced bit takes the synced value and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES resets the count.
  - Worst-case latency from a pin change to SW_STATUS is 2 + DEBOUNCE_CYCLES cycles.
- Edge flags: a 0->1 transition of a debounced bit sets SW_EDGE[i].
  - Flags are sticky and cleared by writing 1 (W1C) to SW_EDGE.
  - If a W1C and a new edge hit the same bit in the same cycle, the new edge wins and the flag stays 1.
- Reads:
  - io_rd samples io_addr. The next cycle, io_rdata holds the register value (zero-extended) and io_rvalid=1.
  - Unmapped offsets 5..7 read 0.
  - io_rdata holds its value until the next read.
- Writes take effect on the clk edge where io_wr=1.
  - LED_DATA keeps only the low LED_WIDTH bits.
  - SW_STATUS is read-only; writes are ignored.
  - CTRL: bit0 led_en, bit1 irq_en; other bits read 0.
- io_rd and io_wr together: both are performed. The read returns the value from before the write.
- led_out = led_en ? LED_DATA (masked by PWM, see Optional Feature) : 0.
- irq = irq_en & (|SW_EDGE), registered, asserted one cycle after the flag sets.
- Reset asserted mid-debounce discards the partial count.
- Reset asserted mid-read drops io_rvalid immediately.

Optional Feature:
- Macro: SWITCH_LED_PWM_EN.
- When defined:
  - An 8-bit free-running counter pwm_cnt wraps 255->0.
  - PWM_DUTY (offset 4, 8 bits RW) gates LEDs: led_out = led_en & (pwm_cnt < PWM_DUTY) ? LED_DATA : 0.
  - Duty 0 gives LEDs always off. Duty 255 gives on 255 of 256 cycles.
- When undefined:
  - No counter is built.
  - Offset 4 reads 0 and writes are ignored.
  - LEDs are full-on whenever led_en=1.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: hold rst=0 with sw_in=19'h7FFFF -> all outputs 0. After release, SW_STATUS reads 19'h7FFFF within 2+4 cycles; SW_EDGE reads 19'h7FFFF.
- Debounce: pulse sw_in[0]=1 for 3 cycles, then 0 -> SW_STATUS[0] stays 0, SW_EDGE=0. Hold sw_in[0]=1 for 6 cycles -> SW_STATUS=1, SW_EDGE[0]=1.
- LED/CTRL: write LED_DATA=32'hFFA5A5A5 with CTRL=0 -> led_out=0. Write CTRL=1 -> led_out=24'hA5A5A5. LED_DATA reads 32'h00A5A5A5.
- IRQ and W1C: CTRL=3, rising edge on sw_in[2] -> irq=1. Write SW_EDGE=4 -> irq=0 next cycle. Repeat with the W1C in the same cycle as a new edge on bit 2 -> flag stays 1, irq stays 1.
- Read timing: io_rd at offset 1 -> io_rvalid=1 exactly one cycle later. Simultaneous io_wr of 32'h1 to offset 1 -> io_rdata returns the old value; a following read returns 1.
- PWM (macro defined): CTRL=1, LED_DATA=24'h1, PWM_DUTY=64 -> led_out[0] high for 64 of every 256 cycles. PWM_DUTY=0 -> always 0.
